// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 matrix keypad scanner.
// Scan/debounce state encodings, row drive pattern and column priority pick.
package keypad_pkg;

    typedef enum logic [1:0] {
        R0 = 2'd0,
        R1 = 2'd1,
        R2 = 2'd2,
        R3 = 2'd3
    } scan_state_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } deb_state_t;

    // Active-low one-hot row drive for each scan state.
    function automatic logic [3:0] row_drive(input scan_state_t s);
        logic [3:0] r;
        case (s)
            R0:      r = 4'b1110;
            R1:      r = 4'b1101;
            R2:      r = 4'b1011;
            R3:      r = 4'b0111;
            default: r = 4'b1110;
        endcase
        return r;
    endfunction

    // Index of the lowest active-low column.
    function automatic logic [1:0] lowest_low_col(input logic [3:0] cols);
        logic [1:0] idx;
        if (cols[0] == 1'b0) begin
            idx = 2'd0;
        end else if (cols[1] == 1'b0) begin
            idx = 2'd1;
        end else if (cols[2] == 1'b0) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Whole-scan debounce of keypad scan results; emits accepted key code,
// a one-cycle valid pulse and a held flag, all registered.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scan_end,
    input  logic       found,
    input  logic [3:0] code,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] TARGET = CW'(DEBOUNCE_SCANS);
    localparam logic [CW-1:0] ONE    = CW'(1);

    deb_state_t    state_r, state_next_s;
    logic [3:0]    cand_r, cand_next_s;
    logic [CW-1:0] cnt_r, cnt_next_s, cnt_inc_s;
    logic [3:0]    code_r, code_next_s;
    logic          valid_r, valid_next_s;
    logic          held_r, held_next_s;
    logic          match_s;

    // Debounce next-state and output decode; only scan-end strobes move it.
    always_comb begin
        state_next_s = state_r;
        cand_next_s  = cand_r;
        cnt_next_s   = cnt_r;
        code_next_s  = code_r;
        valid_next_s = 1'b0;
        match_s      = found && (code == cand_r);
        cnt_inc_s    = cnt_r + ONE;
        if (scan_end) begin
            case (state_r)
                IDLE: begin
                    if (found) begin
                        cand_next_s = code;
                        cnt_next_s  = ONE;
                        if (DEBOUNCE_SCANS == 1) begin
                            code_next_s  = code;
                            valid_next_s = 1'b1;
                            state_next_s = PRESSED;
                        end else begin
                            state_next_s = DEBOUNCE;
                        end
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                DEBOUNCE: begin
                    if (match_s) begin
                        if (cnt_inc_s == TARGET) begin
                            code_next_s  = cand_r;
                            valid_next_s = 1'b1;
                            state_next_s = PRESSED;
                        end else begin
                            cnt_next_s = cnt_inc_s;
                        end
                    end else if (found) begin
                        cand_next_s = code;
                        cnt_next_s  = ONE;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                PRESSED: begin
                    if (match_s) begin
                        state_next_s = PRESSED;
                    end else if (DEBOUNCE_SCANS == 1) begin
                        state_next_s = IDLE;
                    end else begin
                        cnt_next_s   = ONE;
                        state_next_s = RELEASE;
                    end
                end
                RELEASE: begin
                    if (match_s) begin
                        state_next_s = PRESSED;
                    end else if (cnt_inc_s == TARGET) begin
                        state_next_s = IDLE;
                    end else begin
                        cnt_next_s = cnt_inc_s;
                    end
                end
                default: begin
                    state_next_s = IDLE;
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
        held_next_s = (state_next_s == PRESSED) || (state_next_s == RELEASE);
    end

    // Debounce state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cand_r  <= 4'd0;
            cnt_r   <= '0;
            code_r  <= 4'd0;
            valid_r <= 1'b0;
            held_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cand_r  <= cand_next_s;
            cnt_r   <= cnt_next_s;
            code_r  <= code_next_s;
            valid_r <= valid_next_s;
            held_r  <= held_next_s;
        end
    end

    assign key_code  = code_r;
    assign key_valid = valid_r;
    assign key_held  = held_r;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks rows low one at a time, samples the
// synchronized columns at the end of each row dwell, and debounces per scan.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_LIMIT     = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int CNT_W = $clog2(SCAN_LIMIT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SCAN_LIMIT);

    logic [3:0]       col_meta_r, col_sync_r;
    logic [CNT_W-1:0] dwell_r;
    scan_state_t      scan_r, scan_next_s;
    logic [3:0]       row_r;
    logic             found_acc_r;
    logic [3:0]       code_acc_r;
    logic             sample_s, scan_end_s, row_hit_s, scan_found_s;
    logic [1:0]       row_idx_s;
    logic [3:0]       row_code_s, scan_code_s;

    // Two-flop synchronizer; idle (pulled-up) value out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_meta_r <= 4'b1111;
            col_sync_r <= 4'b1111;
        end else begin
            col_meta_r <= col_in;
            col_sync_r <= col_meta_r;
        end
    end

    // Scan FSM next state: advance one row at the end of each dwell.
    always_comb begin
        sample_s    = (dwell_r == LAST);
        scan_next_s = scan_r;
        if (sample_s) begin
            case (scan_r)
                R0:      scan_next_s = R1;
                R1:      scan_next_s = R2;
                R2:      scan_next_s = R3;
                R3:      scan_next_s = R0;
                default: scan_next_s = R0;
            endcase
        end else begin
            scan_next_s = scan_r;
        end
    end

    // Dwell counter, scan state and registered row drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            dwell_r <= '0;
            scan_r  <= R0;
            row_r   <= 4'b1110;
        end else begin
            dwell_r <= sample_s ? '0 : dwell_r + CNT_W'(1);
            scan_r  <= scan_next_s;
            row_r   <= row_drive(scan_next_s);
        end
    end

    // Per-scan detection: an earlier row's hit in this scan takes priority.
    always_comb begin
        row_hit_s  = (col_sync_r != 4'b1111);
        row_idx_s  = scan_r;
        row_code_s = {row_idx_s, lowest_low_col(col_sync_r)};
        if (scan_r == R0) begin
            scan_found_s = row_hit_s;
            scan_code_s  = row_code_s;
        end else if (found_acc_r) begin
            scan_found_s = 1'b1;
            scan_code_s  = code_acc_r;
        end else begin
            scan_found_s = row_hit_s;
            scan_code_s  = row_code_s;
        end
        scan_end_s = sample_s && (scan_r == R3);
    end

    // Partial-scan result carried from row to row.
    always_ff @(posedge clk) begin
        if (rst) begin
            found_acc_r <= 1'b0;
            code_acc_r  <= 4'd0;
        end else if (sample_s) begin
            found_acc_r <= scan_found_s;
            code_acc_r  <= scan_code_s;
        end
    end

    keypad_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .clk      (clk),
        .rst      (rst),
        .scan_end (scan_end_s),
        .found    (scan_found_s),
        .code     (scan_code_s),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    assign row_out = row_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with a 16-cycle scan and 2-scan debounce; the
// keypad is modelled from row_out, accepted codes are scoreboarded.
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] col_in;
    logic [3:0] row_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] keys = 16'h0000;
    logic [3:0]  exp_q[$];
    logic        prev_valid = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    localparam int SCAN = 16;

    typedef struct {
        logic [15:0] keys;
        int          scans;
        logic        push;
        logic [3:0]  exp_code;
        logic        exp_held;
    } vec_t;

    vec_t vecs[13];

    keypad_scanner #(
        .SCAN_LIMIT    (3),
        .DEBOUNCE_SCANS(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .col_in   (col_in),
        .row_out  (row_out),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key pulls its column low while its row is driven.
    always_comb begin
        col_in = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!row_out[r] && keys[r*4+c]) col_in[c] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every valid pulse must match the next queued code.
    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            check("valid_single_cycle", {3'b000, prev_valid}, 4'h0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid: got code %h, expected no pulse (t=%0t)", key_code, $time);
            end else begin
                check("valid_code", key_code, exp_q.pop_front());
            end
        end
        prev_valid = key_valid;
    end

    initial begin
        vecs[0]  = '{16'h0200, 2, 1'b1, 4'h9, 1'b1};  // clean press row2 col1
        vecs[1]  = '{16'h0000, 1, 1'b0, 4'h9, 1'b1};  // first key-free scan
        vecs[2]  = '{16'h0000, 1, 1'b0, 4'h9, 1'b0};  // release completes
        vecs[3]  = '{16'h0200, 1, 1'b0, 4'h9, 1'b0};  // bounce: one scan only
        vecs[4]  = '{16'h0000, 1, 1'b0, 4'h9, 1'b0};
        vecs[5]  = '{16'h0050, 2, 1'b1, 4'h4, 1'b1};  // row1 cols 0 and 2
        vecs[6]  = '{16'h0000, 2, 1'b0, 4'h4, 1'b0};
        vecs[7]  = '{16'h1008, 2, 1'b1, 4'h3, 1'b1};  // row0 col3 + row3 col0
        vecs[8]  = '{16'h0000, 2, 1'b0, 4'h3, 1'b0};
        vecs[9]  = '{16'h0020, 2, 1'b1, 4'h5, 1'b1};
        vecs[10] = '{16'h0400, 3, 1'b0, 4'h5, 1'b0};  // key change: release then re-debounce
        vecs[11] = '{16'h0400, 1, 1'b1, 4'hA, 1'b1};
        vecs[12] = '{16'h0000, 2, 1'b0, 4'hA, 1'b0};

        // Reset state and first row advance.
        repeat (2) @(posedge clk);
        #1;
        check("rst_row_out", row_out, 4'b1110);
        check("rst_key_code", key_code, 4'h0);
        check("rst_key_valid", {3'b000, key_valid}, 4'h0);
        check("rst_key_held", {3'b000, key_held}, 4'h0);
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            if (i == 3) check("row_before_adv", row_out, 4'b1110);
            if (i == 4) check("row_after_adv", row_out, 4'b1101);
        end
        repeat (SCAN - 4) @(posedge clk);
        #1;

        // Table-driven scan sequences, aligned to scan boundaries.
        for (int v = 0; v < 13; v++) begin
            if (vecs[v].push) exp_q.push_back(vecs[v].exp_code);
            keys = vecs[v].keys;
            repeat (SCAN * vecs[v].scans) @(posedge clk);
            #1;
            check($sformatf("v%0d_key_valid", v), {3'b000, key_valid}, {3'b000, vecs[v].push});
            check($sformatf("v%0d_key_held", v), {3'b000, key_held}, {3'b000, vecs[v].exp_held});
            check($sformatf("v%0d_key_code", v), key_code, vecs[v].exp_code);
        end

        // Reset in the middle of the second debounce scan.
        keys = 16'h0200;
        repeat (SCAN + 8) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_row_out", row_out, 4'b1110);
        check("midrst_key_code", key_code, 4'h0);
        check("midrst_key_held", {3'b000, key_held}, 4'h0);
        check("midrst_key_valid", {3'b000, key_valid}, 4'h0);
        rst = 1'b0;
        repeat (SCAN) @(posedge clk);
        #1;
        check("post_rst_scan1_held", {3'b000, key_held}, 4'h0);
        check("post_rst_scan1_valid", {3'b000, key_valid}, 4'h0);
        exp_q.push_back(4'h9);
        repeat (SCAN) @(posedge clk);
        #1;
        check("post_rst_scan2_valid", {3'b000, key_valid}, 4'h1);
        check("post_rst_scan2_held", {3'b000, key_held}, 4'h1);
        check("post_rst_scan2_code", key_code, 4'h9);
        keys = 16'h0000;
        repeat (2 * SCAN) @(posedge clk);
        #1;
        check("post_rst_release_held", {3'b000, key_held}, 4'h0);

        repeat (4) @(posedge clk);
        check("queue_drained", 4'(exp_q.size()), 4'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
